// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake with timeout, store lane
// formatting, load alignment/extension and the MEM/WB pipeline register.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result_mem,
  input  logic [DATA_W-1:0] read_data2_forwarded_mem,
  input  logic [2:0]        funct3_mem,
  input  logic [RD_W-1:0]   rd_mem,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic              memtoreg_mem,
  input  logic              regwrite_mem,
  input  logic              branchjalx_mem,
  input  logic [PC_W-1:0]   pcplus4_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              regwrite_wb,
  output logic [RD_W-1:0]   rd_wb,
  output logic              memtoreg_wb,
  output logic              branchjalx_wb,
  output logic [DATA_W-1:0] read_data_wb,
  output logic [DATA_W-1:0] alu_result_wb,
  output logic [PC_W-1:0]   pcplus4_wb
);

  localparam int CNT_W = 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_mem;
  logic              misaligned;
  logic              access;
  logic              at_limit;
  logic              timeout;
  logic [1:0]        off;
  logic [DATA_W-1:0] load_data;

  // Byte/half selection by address offset, sign- or zero-extended per funct3.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [2:0]        f3,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] word
  );
    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] b_sx;
    logic signed [DATA_W-1:0] h_sx;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    b_sx    = b;
    h_sx    = h;
    case (f3)
      3'b000:  return b_sx;
      3'b001:  return h_sx;
      3'b100:  return {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  assign off        = alu_result_mem[1:0];
  assign is_mem     = memread_mem | memwrite_mem;
  assign misaligned = is_mem & (((funct3_mem[1:0] == 2'b01) & off[0]) |
                                ((funct3_mem[1:0] == 2'b10) & (off != 2'b00)));
  assign access     = is_mem & ~misaligned;
  assign at_limit   = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
  assign timeout    = access & ~dmem_ack & at_limit;

  // rst gates the request path so a reset mid-transaction drops req at once.
  assign dmem_req  = ~rst & access;
  assign mem_stall = ~rst & access & ~dmem_ack & ~at_limit;
  assign dmem_we   = memwrite_mem;
  assign dmem_addr = {alu_result_mem[DATA_W-1:2], 2'b00};
  assign load_data = load_extend(funct3_mem, off, dmem_rdata);

  always_comb begin
    dmem_wstrb = 4'h0;
    dmem_wdata = read_data2_forwarded_mem;
    case (funct3_mem[1:0])
      2'b00: begin
        dmem_wstrb = 4'b0001 << off;
        dmem_wdata = {4{read_data2_forwarded_mem[7:0]}};
      end
      2'b01: begin
        dmem_wstrb = 4'b0011 << off;
        dmem_wdata = {2{read_data2_forwarded_mem[15:0]}};
      end
      default: dmem_wstrb = 4'hF;
    endcase
    if (!memwrite_mem) dmem_wstrb = 4'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ack || at_limit || !access) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- MEM/WB boundary: bubble while stalled, squash writeback on errors ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
      regwrite_wb   <= 1'b0;
      rd_wb         <= '0;
      memtoreg_wb   <= 1'b0;
      branchjalx_wb <= 1'b0;
      read_data_wb  <= '0;
      alu_result_wb <= '0;
      pcplus4_wb    <= '0;
    end else begin
      misalign_err <= misaligned;
      bus_err      <= timeout;
      if (mem_stall) begin
        regwrite_wb   <= 1'b0;
        rd_wb         <= '0;
        memtoreg_wb   <= 1'b0;
        branchjalx_wb <= 1'b0;
        read_data_wb  <= '0;
        alu_result_wb <= '0;
        pcplus4_wb    <= '0;
      end else begin
        rd_wb         <= rd_mem;
        branchjalx_wb <= branchjalx_mem;
        alu_result_wb <= alu_result_mem;
        pcplus4_wb    <= pcplus4_mem;
        if (misaligned || timeout) begin
          regwrite_wb  <= 1'b0;
          memtoreg_wb  <= 1'b0;
          read_data_wb <= '0;
        end else begin
          regwrite_wb  <= regwrite_mem;
          memtoreg_wb  <= memtoreg_mem;
          read_data_wb <= memread_mem ? load_data : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected MEM/WB results are queued when an access is
// driven and compared when the stage releases the stall.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_mem, read_data2_forwarded_mem, pcplus4_mem;
  logic [2:0]  funct3_mem;
  logic [4:0]  rd_mem;
  logic        memread_mem, memwrite_mem, memtoreg_mem, regwrite_mem, branchjalx_mem;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        regwrite_wb, memtoreg_wb, branchjalx_wb;
  logic [4:0]  rd_wb;
  logic [31:0] read_data_wb, alu_result_wb, pcplus4_wb;

  typedef struct {
    logic        regwrite;
    logic [4:0]  rd;
    logic        memtoreg;
    logic        bjx;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        mis;
    logic        bus;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  mem_stage_lsu #(.DATA_W(32), .PC_W(32), .RD_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .alu_result_mem(alu_result_mem), .read_data2_forwarded_mem(read_data2_forwarded_mem),
    .funct3_mem(funct3_mem), .rd_mem(rd_mem), .memread_mem(memread_mem),
    .memwrite_mem(memwrite_mem), .memtoreg_mem(memtoreg_mem), .regwrite_mem(regwrite_mem),
    .branchjalx_mem(branchjalx_mem), .pcplus4_mem(pcplus4_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .misalign_err(misalign_err), .bus_err(bus_err),
    .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .memtoreg_wb(memtoreg_wb),
    .branchjalx_wb(branchjalx_wb), .read_data_wb(read_data_wb),
    .alu_result_wb(alu_result_wb), .pcplus4_wb(pcplus4_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input wb_t e);
    chk({tag, ".regwrite_wb"},   regwrite_wb,   e.regwrite);
    chk({tag, ".rd_wb"},         rd_wb,         e.rd);
    chk({tag, ".memtoreg_wb"},   memtoreg_wb,   e.memtoreg);
    chk({tag, ".branchjalx_wb"}, branchjalx_wb, e.bjx);
    chk({tag, ".read_data_wb"},  read_data_wb,  e.rdata);
    chk({tag, ".alu_result_wb"}, alu_result_wb, e.alu);
    chk({tag, ".pcplus4_wb"},    pcplus4_wb,    e.pc4);
    chk({tag, ".misalign_err"},  misalign_err,  e.mis);
    chk({tag, ".bus_err"},       bus_err,       e.bus);
  endtask

  // Presents one EX/MEM instruction, acks on cycle ack_after (-1 = never), checks the
  // bus side each cycle and pops the queued writeback expectation on release.
  task automatic run_op(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic m2r, input logic rw, input logic bjx, input logic [31:0] pc4,
                        input int ack_after, input logic [31:0] rdata, input logic exp_access,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    logic        ack_now;
    logic        stall_exp;
    logic [31:0] exp_addr;
    wb_t         e;
    memread_mem = mr; memwrite_mem = mw; funct3_mem = f3; alu_result_mem = addr;
    read_data2_forwarded_mem = wd; rd_mem = rd; memtoreg_mem = m2r; regwrite_mem = rw;
    branchjalx_mem = bjx; pcplus4_mem = pc4;
    exp_addr = {addr[31:2], 2'b00};
    for (int k = 0; k <= TO + 2; k++) begin
      ack_now    = (k == ack_after);
      stall_exp  = exp_access && !ack_now && (k < TO);
      dmem_ack   = ack_now;
      dmem_rdata = ack_now ? rdata : 32'h0;
      #1;
      chk({tag, ".dmem_req"},  dmem_req,  exp_access);
      chk({tag, ".mem_stall"}, mem_stall, stall_exp);
      if (exp_access) begin
        chk({tag, ".dmem_we"},    dmem_we,    mw);
        chk({tag, ".dmem_addr"},  dmem_addr,  exp_addr);
        chk({tag, ".dmem_wstrb"}, dmem_wstrb, exp_wstrb);
        if (mw) chk({tag, ".dmem_wdata"}, dmem_wdata, exp_wdata);
      end
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      if (!stall_exp) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
          e = exp_q.pop_front();
          chk_wb(tag, e);
        end
        return;
      end
      chk({tag, ".bubble_regwrite"}, regwrite_wb, 1'b0);
      chk({tag, ".bubble_alu"},      alu_result_wb, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alu_result_mem = 0; read_data2_forwarded_mem = 0; pcplus4_mem = 0; funct3_mem = 0;
    rd_mem = 0; memread_mem = 0; memwrite_mem = 0; memtoreg_mem = 0; regwrite_mem = 0;
    branchjalx_mem = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_wb("reset", '{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    chk("reset.dmem_req", dmem_req, 1'b0);
    chk("reset.mem_stall", mem_stall, 1'b0);
    rst = 1'b0;

    exp_q.push_back('{1'b1, 5'd5, 1'b1, 1'b0, 32'hDEADBEEF, 32'h100, 32'h1004, 1'b0, 1'b0});
    run_op("lw_wait3", 1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 1, 0, 32'h1004, 3, 32'hDEADBEEF, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd6, 1'b1, 1'b0, 32'hFFFFFF80, 32'h103, 32'h1008, 1'b0, 1'b0});
    run_op("lb", 1, 0, 3'b000, 32'h103, 0, 5'd6, 1, 1, 0, 32'h1008, 0, 32'h80FF0000, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd6, 1'b1, 1'b0, 32'h00000080, 32'h103, 32'h100C, 1'b0, 1'b0});
    run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 5'd6, 1, 1, 0, 32'h100C, 0, 32'h80FF0000, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd7, 1'b1, 1'b0, 32'hFFFF8001, 32'h102, 32'h1010, 1'b0, 1'b0});
    run_op("lh", 1, 0, 3'b001, 32'h102, 0, 5'd7, 1, 1, 0, 32'h1010, 0, 32'h80011234, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd7, 1'b1, 1'b0, 32'h00008001, 32'h102, 32'h1014, 1'b0, 1'b0});
    run_op("lhu", 1, 0, 3'b101, 32'h102, 0, 5'd7, 1, 1, 0, 32'h1014, 1, 32'h80011234, 1, 4'h0, 0);

    exp_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h102, 32'h1018, 1'b0, 1'b0});
    run_op("sh", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 0, 0, 0, 32'h1018, 1, 0, 1, 4'b1100, 32'hABCDABCD);

    exp_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h101, 32'h101C, 1'b0, 1'b0});
    run_op("sb", 0, 1, 3'b000, 32'h101, 32'h0000005A, 5'd0, 0, 0, 0, 32'h101C, 0, 0, 1, 4'b0010, 32'h5A5A5A5A);

    exp_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h1020, 1'b0, 1'b0});
    run_op("sw", 0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 5'd0, 0, 0, 0, 32'h1020, 2, 0, 1, 4'hF, 32'hCAFEF00D);

    exp_q.push_back('{1'b0, 5'd8, 1'b0, 1'b0, 32'h0, 32'h101, 32'h1024, 1'b1, 1'b0});
    run_op("lw_misalign", 1, 0, 3'b010, 32'h101, 0, 5'd8, 1, 1, 0, 32'h1024, -1, 0, 0, 4'h0, 0);

    exp_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h103, 32'h1028, 1'b1, 1'b0});
    run_op("sh_misalign", 0, 1, 3'b001, 32'h103, 32'h1111, 5'd0, 0, 0, 0, 32'h1028, -1, 0, 0, 4'h0, 0);

    exp_q.push_back('{1'b0, 5'd9, 1'b0, 1'b0, 32'h0, 32'h300, 32'h102C, 1'b0, 1'b1});
    run_op("lw_timeout", 1, 0, 3'b010, 32'h300, 0, 5'd9, 1, 1, 0, 32'h102C, -1, 0, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd10, 1'b1, 1'b0, 32'h13579BDF, 32'h304, 32'h1030, 1'b0, 1'b0});
    run_op("lw_ack_at_limit", 1, 0, 3'b010, 32'h304, 0, 5'd10, 1, 1, 0, 32'h1030, TO, 32'h13579BDF, 1, 4'h0, 0);

    exp_q.push_back('{1'b1, 5'd1, 1'b0, 1'b1, 32'h0, 32'h123, 32'h2008, 1'b0, 1'b0});
    run_op("jal_idle_ack", 0, 0, 3'b000, 32'h123, 0, 5'd1, 0, 1, 1, 32'h2008, 0, 32'hFFFFFFFF, 0, 4'h0, 0);

    // Reset asserted in the middle of a pending load.
    memread_mem = 1; memwrite_mem = 0; funct3_mem = 3'b010; alu_result_mem = 32'h400;
    rd_mem = 5'd11; memtoreg_mem = 1; regwrite_mem = 1; branchjalx_mem = 0; pcplus4_mem = 32'h3000;
    dmem_ack = 0;
    #1;
    chk("rst_wait.stall_before", mem_stall, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_wait.dmem_req", dmem_req, 1'b0);
    chk("rst_wait.mem_stall", mem_stall, 1'b0);
    chk_wb("rst_wait", '{1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;

    exp_q.push_back('{1'b0, 5'd2, 1'b0, 1'b0, 32'h0, 32'h55, 32'h3004, 1'b0, 1'b0});
    run_op("late_ack_ignored", 0, 0, 3'b000, 32'h55, 0, 5'd2, 0, 0, 0, 32'h3004, 0, 32'hA5A5A5A5, 0, 4'h0, 0);

    exp_q.push_back('{1'b0, 5'd12, 1'b0, 1'b0, 32'h0, 32'h408, 32'h3008, 1'b0, 1'b1});
    run_op("timeout_after_rst", 1, 0, 3'b010, 32'h408, 0, 5'd12, 1, 1, 0, 32'h3008, -1, 0, 1, 4'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
